adc_channel_deskew: RTL and testbench

- Sits directly downstream of the four-channel ADC data interface, in the clk domain.
- Consumes the per-channel H/L parallel sample buses (A–D) and removes integer-cycle skew between channels.
- Skew is measured with a training marker the ADCs emit on command. Each earlier-arriving channel is then delayed through a per-channel delay line, so all channels leave aligned on the same clk cycle.
- Provides lock and fail status for the control/register block.

---
 rtl/adc_channel_deskew.sv | 204 ++++++++++++++++++++
 tb/tb_adc_channel_deskew.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_channel_deskew.sv
// Four-channel ADC deskew: measures integer-cycle skew from a training marker and
// delays the earlier channels so all four buses leave on the same clk cycle.
module adc_channel_deskew #(
  parameter int                        ADC_DATA_WIDTH    = 8,
  parameter int                        PARALLEL_PATH_NUM = 2,
  parameter logic [ADC_DATA_WIDTH-1:0] MARKER            = 8'h7F,
  parameter int                        MAX_SKEW          = 7,
  parameter int                        SEARCH_TIMEOUT    = 1023
) (
  input  logic                                        clk,
  input  logic                                        arst_data_sync,
  input  logic                                        align_start,
  input  logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] din_AH,
  input  logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] din_AL,
  input  logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] din_BH,
  input  logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] din_BL,
  input  logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] din_CH,
  input  logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] din_CL,
  input  logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] din_DH,
  input  logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] din_DL,
  output logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dout_AH,
  output logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dout_AL,
  output logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dout_BH,
  output logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dout_BL,
  output logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dout_CH,
  output logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dout_CL,
  output logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dout_DH,
  output logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dout_DL,
  output logic                                        aligned,
  output logic                                        align_fail,
  output logic                                        busy,
  output logic [$clog2(MAX_SKEW+1)-1:0]               delay_A,
  output logic [$clog2(MAX_SKEW+1)-1:0]               delay_B,
  output logic [$clog2(MAX_SKEW+1)-1:0]               delay_C,
  output logic [$clog2(MAX_SKEW+1)-1:0]               delay_D
);

  localparam int BW = ADC_DATA_WIDTH * PARALLEL_PATH_NUM;
  localparam int WW = 2 * BW;
  localparam int DW = $clog2(MAX_SKEW + 1);
  localparam int CW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int NW = $clog2(MAX_SKEW + 2);

  typedef enum logic [2:0] {StIdle, StArm, StSearch, StLocked, StFail} state_e;

  state_e state_q, state_d;
  logic   aligned_q, aligned_d, fail_q, fail_d, busy_q, busy_d;

  logic [WW-1:0] din_ch [4];
  logic [3:0]    match;

  assign din_ch[0] = {din_AH, din_AL};
  assign din_ch[1] = {din_BH, din_BL};
  assign din_ch[2] = {din_CH, din_CL};
  assign din_ch[3] = {din_DH, din_DL};
  assign match[0]  = (din_AH[ADC_DATA_WIDTH-1:0] == MARKER);
  assign match[1]  = (din_BH[ADC_DATA_WIDTH-1:0] == MARKER);
  assign match[2]  = (din_CH[ADC_DATA_WIDTH-1:0] == MARKER);
  assign match[3]  = (din_DH[ADC_DATA_WIDTH-1:0] == MARKER);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] arr_q [4];
  logic [3:0]    hit_q;
  logic          started_q;
  logic [NW-1:0] win_q;
  logic [DW-1:0] delay_q [4];

  logic [3:0]    hit_new, hit_all;
  logic          all_hit, skew_ok, win_expired, timed_out;
  logic [CW-1:0] arr_eff [4];
  logic [DW-1:0] delay_calc [4];

  // The last channel to hit always hits on the current cycle, so cnt_q is max(arr).
  always_comb begin
    hit_new     = match & ~hit_q;
    hit_all     = match | hit_q;
    all_hit     = &hit_all;
    skew_ok     = !started_q || (win_q < NW'(MAX_SKEW));
    win_expired = started_q && (win_q >= NW'(MAX_SKEW));
    timed_out   = (hit_all == 4'b0000) && (cnt_q >= CW'(SEARCH_TIMEOUT - 1));
    for (int i = 0; i < 4; i++) begin
      arr_eff[i]    = hit_new[i] ? cnt_q : arr_q[i];
      delay_calc[i] = DW'(cnt_q - arr_eff[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (arst_data_sync) begin
      state_q   <= StIdle;
      aligned_q <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      aligned_q <= aligned_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (align_start) state_d = StArm;
      StArm:    state_d = align_start ? StArm : StSearch;
      StSearch: begin
        if (align_start) begin
          state_d = StArm;
        end else if (all_hit) begin
          state_d = skew_ok ? StLocked : StFail;
        end else if (win_expired || timed_out) begin
          state_d = StFail;
        end
      end
      StLocked: if (align_start) state_d = StArm;
      StFail:   if (align_start) state_d = StArm;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    aligned_d = (state_q == StLocked);
    fail_d    = (state_q == StFail);
    busy_d    = (state_q == StArm) || (state_q == StSearch);
  end

  always_ff @(posedge clk) begin
    if (arst_data_sync) begin
      cnt_q     <= '0;
      hit_q     <= '0;
      started_q <= 1'b0;
      win_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        arr_q[i]   <= '0;
        delay_q[i] <= '0;
      end
    end else if (state_q == StArm) begin
      cnt_q     <= '0;
      hit_q     <= '0;
      started_q <= 1'b0;
      win_q     <= '0;
      for (int i = 0; i < 4; i++) delay_q[i] <= '0;
    end else if (state_q == StSearch) begin
      if (cnt_q != CW'(SEARCH_TIMEOUT)) cnt_q <= cnt_q + CW'(1);
      hit_q <= hit_all;
      for (int i = 0; i < 4; i++) begin
        if (hit_new[i]) arr_q[i] <= cnt_q;
      end
      if (!started_q && (hit_new != 4'b0000)) begin
        started_q <= 1'b1;
        win_q     <= '0;
      end else if (started_q && (win_q != NW'(MAX_SKEW + 1))) begin
        win_q <= win_q + NW'(1);
      end
      if (state_d == StLocked) begin
        for (int i = 0; i < 4; i++) delay_q[i] <= delay_calc[i];
      end
    end
  end

  // tap[i][k] is channel i delayed by k cycles; tap 0 is the live input.
  logic [WW-1:0] sr_q   [4][MAX_SKEW];
  logic [WW-1:0] tap    [4][MAX_SKEW+1];
  logic [WW-1:0] dout_q [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tap[i][0] = din_ch[i];
      for (int k = 1; k <= MAX_SKEW; k++) tap[i][k] = sr_q[i][k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (arst_data_sync) begin
      for (int i = 0; i < 4; i++) begin
        dout_q[i] <= '0;
        for (int k = 0; k < MAX_SKEW; k++) sr_q[i][k] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        sr_q[i][0] <= din_ch[i];
        for (int k = 1; k < MAX_SKEW; k++) sr_q[i][k] <= sr_q[i][k-1];
        dout_q[i] <= tap[i][delay_q[i]];
      end
    end
  end

  assign dout_AH    = dout_q[0][WW-1:BW];
  assign dout_AL    = dout_q[0][BW-1:0];
  assign dout_BH    = dout_q[1][WW-1:BW];
  assign dout_BL    = dout_q[1][BW-1:0];
  assign dout_CH    = dout_q[2][WW-1:BW];
  assign dout_CL    = dout_q[2][BW-1:0];
  assign dout_DH    = dout_q[3][WW-1:BW];
  assign dout_DL    = dout_q[3][BW-1:0];
  assign delay_A    = delay_q[0];
  assign delay_B    = delay_q[1];
  assign delay_C    = delay_q[2];
  assign delay_D    = delay_q[3];
  assign aligned    = aligned_q;
  assign align_fail = fail_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_adc_channel_deskew.sv
// Directed bench for adc_channel_deskew: reset/pass-through vector table plus
// hand-written alignment, window, timeout and reset sequences.
module tb_adc_channel_deskew;

  localparam int BW   = 16;
  localparam int MAXS = 7;
  localparam int TO   = 1023;
  localparam int HN   = 4096;

  logic clk;
  logic rst, start;
  logic [BW-1:0] din_AH, din_AL, din_BH, din_BL, din_CH, din_CL, din_DH, din_DL;
  logic [BW-1:0] dout_AH, dout_AL, dout_BH, dout_BL, dout_CH, dout_CL, dout_DH, dout_DL;
  logic aligned, align_fail, busy;
  logic [2:0] delay_A, delay_B, delay_C, delay_D;

  adc_channel_deskew #(
    .ADC_DATA_WIDTH   (8),
    .PARALLEL_PATH_NUM(2),
    .MARKER           (8'h7F),
    .MAX_SKEW         (MAXS),
    .SEARCH_TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .arst_data_sync(rst),
    .align_start   (start),
    .din_AH(din_AH), .din_AL(din_AL), .din_BH(din_BH), .din_BL(din_BL),
    .din_CH(din_CH), .din_CL(din_CL), .din_DH(din_DH), .din_DL(din_DL),
    .dout_AH(dout_AH), .dout_AL(dout_AL), .dout_BH(dout_BH), .dout_BL(dout_BL),
    .dout_CH(dout_CH), .dout_CL(dout_CL), .dout_DH(dout_DH), .dout_DL(dout_DL),
    .aligned   (aligned),
    .align_fail(align_fail),
    .busy      (busy),
    .delay_A(delay_A), .delay_B(delay_B), .delay_C(delay_C), .delay_D(delay_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] dout_w [4];
  assign dout_w[0] = {dout_AH, dout_AL};
  assign dout_w[1] = {dout_BH, dout_BL};
  assign dout_w[2] = {dout_CH, dout_CL};
  assign dout_w[3] = {dout_DH, dout_DL};

  int n_tests, n_fail, cyc;
  logic [31:0] hist [4][HN];
  bit ramp_mode;
  int off [4];

  typedef struct packed {
    logic            rst;
    logic [3:0][31:0] din;
    logic [3:0][31:0] exp;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [31:0] data_word(int ch, int c);
    logic [31:0] w;
    w = {4'(ch), 4'(c), 1'b1, 7'(c), 16'(c * 3 + ch)};
    return w;
  endfunction

  function automatic logic [31:0] ramp_word(int r);
    logic [31:0] w;
    w = {8'h00, 1'b1, 7'(r), 16'(r)};
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_status(input logic a, input logic f, input logic b);
    chk("status{aligned,fail,busy}", {29'b0, aligned, align_fail, busy}, {29'b0, a, f, b});
  endtask

  task automatic chk_delays(input int d0, input int d1, input int d2, input int d3);
    chk("delay_A", 32'(delay_A), 32'(d0));
    chk("delay_B", 32'(delay_B), 32'(d1));
    chk("delay_C", 32'(delay_C), 32'(d2));
    chk("delay_D", 32'(delay_D), 32'(d3));
  endtask

  task automatic chk_hist(input int d0, input int d1, input int d2, input int d3);
    int d [4];
    d = '{d0, d1, d2, d3};
    for (int ch = 0; ch < 4; ch++)
      chk($sformatf("dout_ch%0d_delayed", ch), dout_w[ch], hist[ch][cyc-1-d[ch]]);
  endtask

  task automatic drive(input logic [3:0][31:0] w, input bit st, input bit r);
    {din_AH, din_AL} = w[0];
    {din_BH, din_BL} = w[1];
    {din_CH, din_CL} = w[2];
    {din_DH, din_DL} = w[3];
    start = st;
    rst   = r;
    if (cyc < HN) for (int ch = 0; ch < 4; ch++) hist[ch][cyc] = w[ch];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic [3:0] mk, input bit st = 1'b0, input bit r = 1'b0);
    logic [3:0][31:0] w;
    for (int ch = 0; ch < 4; ch++) begin
      w[ch] = ramp_mode ? ramp_word(cyc - off[ch]) : data_word(ch, cyc);
      if (mk[ch]) w[ch][23:16] = 8'h7F;
    end
    drive(w, st, r);
  endtask

  // Markers A@t, D@t+1, B@t+2, C@t+5, then a ramp skewed the same way.
  task automatic lock_5304();
    step(4'b0000, 1'b1);
    step(4'b0000);
    step(4'b0000);
    step(4'b0001);
    step(4'b1000);
    step(4'b0010);
    step(4'b0000);
    step(4'b0000);
    chk_status(1'b0, 1'b0, 1'b1);
    step(4'b0100);
    chk_delays(5, 3, 0, 4);
    ramp_mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(4'b0000);
      if (k == 1) chk_status(1'b1, 1'b0, 1'b0);
      if (k >= 6)
        for (int ch = 0; ch < 4; ch++)
          chk($sformatf("ramp_ch%0d", ch), dout_w[ch], ramp_word(cyc - 6));
    end
    ramp_mode = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    ramp_mode = 1'b0;
    off       = '{0, 2, 5, 1};

    vecs[0] = '{rst: 1'b1,
                din: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                exp: '0};
    vecs[1] = '{rst: 1'b0,
                din: {32'hD0D1D2D3, 32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3},
                exp: {32'hD0D1D2D3, 32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3}};
    vecs[2] = '{rst: 1'b0,
                din: {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h9ABCDEF0, 32'h12345678},
                exp: {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h9ABCDEF0, 32'h12345678}};
    vecs[3] = '{rst: 1'b1,
                din: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                exp: '0};
    vecs[4] = '{rst: 1'b0,
                din: {32'h007F0000, 32'h007F0000, 32'h007F0000, 32'h007F0000},
                exp: {32'h007F0000, 32'h007F0000, 32'h007F0000, 32'h007F0000}};
    vecs[5] = '{rst: 1'b0,
                din: {32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF},
                exp: {32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF}};

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].din, 1'b0, vecs[i].rst);
      for (int ch = 0; ch < 4; ch++)
        chk($sformatf("vec%0d_dout_ch%0d", i, ch), dout_w[ch], vecs[i].exp[ch]);
      chk_status(1'b0, 1'b0, 1'b0);
      chk_delays(0, 0, 0, 0);
    end

    // All four markers on the same cycle.
    step(4'b0000, 1'b1);
    step(4'b0000);
    chk_status(1'b0, 1'b0, 1'b1);
    step(4'b0000);
    step(4'b1111);
    chk_delays(0, 0, 0, 0);
    chk_status(1'b0, 1'b0, 1'b1);
    step(4'b0000);
    chk_status(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(4'b0000);
      chk_hist(0, 0, 0, 0);
    end

    lock_5304();

    // Re-align from LOCKED: delays held through ARM entry, then snap to 0.
    step(4'b0000, 1'b1);
    chk_delays(5, 3, 0, 4);
    step(4'b0000);
    chk_delays(0, 0, 0, 0);
    chk_status(1'b0, 1'b0, 1'b1);
    step(4'b0000);
    step(4'b1111);
    chk_delays(0, 0, 0, 0);
    step(4'b0000);
    chk_status(1'b1, 1'b0, 1'b0);

    lock_5304();

    // A@t, D@t+8: window expires at t+8.
    step(4'b0000, 1'b1);
    step(4'b0000);
    step(4'b0000);
    step(4'b0001);
    repeat (7) step(4'b0000);
    chk_status(1'b0, 1'b0, 1'b1);
    step(4'b1000);
    chk_status(1'b0, 1'b0, 1'b1);
    step(4'b0000);
    chk_status(1'b0, 1'b1, 1'b0);
    chk_delays(0, 0, 0, 0);

    // Skew of exactly MAX_SKEW still locks: A@t, B/C@t+3, D@t+7.
    step(4'b0000, 1'b1);
    step(4'b0000);
    step(4'b0000);
    step(4'b0001);
    step(4'b0000);
    step(4'b0000);
    step(4'b0110);
    repeat (3) step(4'b0000);
    step(4'b1000);
    chk_delays(7, 4, 4, 0);
    step(4'b0000);
    chk_status(1'b1, 1'b0, 1'b0);
    step(4'b0000);
    chk_hist(7, 4, 4, 0);

    // Reset mid-search after two hits, with align_start also high.
    step(4'b0000, 1'b1);
    step(4'b0000);
    step(4'b0000);
    step(4'b0011);
    step(4'b0000, 1'b1, 1'b1);
    chk_status(1'b0, 1'b0, 1'b0);
    chk_delays(0, 0, 0, 0);
    for (int ch = 0; ch < 4; ch++) chk($sformatf("rst_dout_ch%0d", ch), dout_w[ch], 32'h0);
    step(4'b0000);
    chk_status(1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000);
    step(4'b0000);
    step(4'b1111);
    chk_delays(0, 0, 0, 0);
    step(4'b0000);
    chk_status(1'b1, 1'b0, 1'b0);

    // No marker: align_fail rises TO+2 edges after the align_start edge.
    step(4'b0000, 1'b1);
    for (int k = 1; k <= TO + 2; k++) begin
      step(4'b0000);
      if (k <= TO + 1) chk("timeout_wait", {29'b0, aligned, align_fail, busy}, 32'b001);
      else             chk("timeout_expire", {29'b0, aligned, align_fail, busy}, 32'b010);
    end
    chk_delays(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
